// File: rtl/corruption_pkg.sv
// Shared types and helpers for the locked-netlist corruption scoring stage.
package corruption_pkg;

  localparam int DEF_WIDTH = 17;
  localparam int DEF_KEY_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Add two unsigned values and clamp to the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/output_corruption_counter_popcount.sv
// Combinational population count: number of set bits in i_data.
module popcount
  import corruption_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_count
);

  localparam int OUT_W = $clog2(WIDTH + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/output_corruption_counter.sv
// Scores one key trial: counts erroneous vectors, total flipped bits and worst per-vector
// Hamming distance between locked and golden outputs over N_VECTORS accepted samples.
module output_corruption_counter
  import corruption_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_VECTORS = 5000,
  parameter int CNT_W     = 16,
  parameter int HD_W      = 24,
  parameter int KEY_W     = DEF_KEY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [KEY_W-1:0]             key_i,
  input  logic                         vld_i,
  input  logic [WIDTH-1:0]             locked_i,
  input  logic [WIDTH-1:0]             golden_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [KEY_W-1:0]             key_o,
  output logic [CNT_W-1:0]             err_vec_cnt_o,
  output logic [HD_W-1:0]              bit_flip_cnt_o,
  output logic [$clog2(WIDTH+1)-1:0]   max_hd_o
);

  localparam int HDW = $clog2(WIDTH + 1);
  localparam int SCW = $clog2(N_VECTORS + 1);
  localparam logic [SCW-1:0] LAST_IDX = SCW'(N_VECTORS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [SCW-1:0]   r_smp_cnt;
  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_diff;
  logic [HDW-1:0]   w_hd;
  logic [CNT_W-1:0] r_err;
  logic [HD_W-1:0]  r_flip;
  logic [HDW-1:0]   r_max;
  logic [KEY_W-1:0] r_key;
  logic             r_done;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_err_sum;
  logic [HD_W-1:0]  w_flip_sum;

  assign w_start_ok = (r_state == IDLE) && start_i;
  assign w_accept   = (r_state == RUN) && vld_i;
  assign w_last     = w_accept && (r_smp_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = RUN;
      RUN:     if (w_last)  w_next = DRAIN;
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != IDLE);
  end

  // Stage 1: capture the bitwise difference of each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_diff <= '0;
      r_smp_cnt <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_s1_diff <= locked_i ^ golden_i;
      if (w_start_ok)    r_smp_cnt <= '0;
      else if (w_accept) r_smp_cnt <= r_smp_cnt + SCW'(1);
    end
  end

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .i_data  (r_s1_diff),
    .o_count (w_hd)
  );

  assign w_err_sum  = CNT_W'(sat_add(32'(r_err), (w_hd != '0) ? 32'd1 : 32'd0, CNT_W));
  assign w_flip_sum = HD_W'(sat_add(32'(r_flip), 32'(w_hd), HD_W));

  // Stage 2: fold the Hamming distance into the trial metrics; DRAIN lasts exactly the
  // cycle in which the final sample is folded, so done follows it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err  <= '0;
      r_flip <= '0;
      r_max  <= '0;
      r_key  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN);
      if (w_start_ok) begin
        r_err  <= '0;
        r_flip <= '0;
        r_max  <= '0;
        r_key  <= key_i;
      end else if (r_s1_vld) begin
        r_err  <= w_err_sum;
        r_flip <= w_flip_sum;
        if (w_hd > r_max) r_max <= w_hd;
      end
    end
  end

  assign done_o         = r_done;
  assign key_o          = r_key;
  assign err_vec_cnt_o  = r_err;
  assign bit_flip_cnt_o = r_flip;
  assign max_hd_o       = r_max;

endmodule

// File: tb/tb_output_corruption_counter.sv
// Scoreboard bench: instance A (N_VECTORS=4) and instance B (N_VECTORS=5, 2-bit error counter);
// stimulus pushes expected trial results, monitors pop and compare on each done_o.
module tb_output_corruption_counter;

  localparam int W  = 17;
  localparam int KW = 32;
  localparam int HW = 24;
  localparam int MW = $clog2(W + 1);

  typedef struct packed {
    logic [KW-1:0] key;
    logic [15:0]   err;
    logic [HW-1:0] flips;
    logic [MW-1:0] maxhd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          startA = 1'b0;
  logic          startB = 1'b0;
  logic          vld = 1'b0;
  logic [KW-1:0] keyI = '0;
  logic [W-1:0]  locked = '0;
  logic [W-1:0]  golden = '0;

  logic          busyA, doneA;
  logic [KW-1:0] keyA;
  logic [15:0]   errA;
  logic [HW-1:0] flipA;
  logic [MW-1:0] maxA;

  logic          busyB, doneB;
  logic [KW-1:0] keyB;
  logic [1:0]    errB;
  logic [HW-1:0] flipB;
  logic [MW-1:0] maxB;

  exp_t expQA[$];
  exp_t expQB[$];
  int   nChecks = 0;
  int   nPass = 0;

  always #5 clk = ~clk;

  output_corruption_counter #(.WIDTH(W), .N_VECTORS(4), .CNT_W(16), .HD_W(HW), .KEY_W(KW)) dutA (
    .clk(clk), .rst(rst), .start_i(startA), .key_i(keyI), .vld_i(vld),
    .locked_i(locked), .golden_i(golden), .busy_o(busyA), .done_o(doneA), .key_o(keyA),
    .err_vec_cnt_o(errA), .bit_flip_cnt_o(flipA), .max_hd_o(maxA)
  );

  output_corruption_counter #(.WIDTH(W), .N_VECTORS(5), .CNT_W(2), .HD_W(HW), .KEY_W(KW)) dutB (
    .clk(clk), .rst(rst), .start_i(startB), .key_i(keyI), .vld_i(vld),
    .locked_i(locked), .golden_i(golden), .busy_o(busyB), .done_o(doneB), .key_o(keyB),
    .err_vec_cnt_o(errB), .bit_flip_cnt_o(flipB), .max_hd_o(maxB)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t mkExp(input logic [31:0] k, input int e, input int f, input int m);
    exp_t r;
    r.key   = k;
    r.err   = 16'(e);
    r.flips = HW'(f);
    r.maxhd = MW'(m);
    return r;
  endfunction

  initial begin : monitorA
    exp_t e;
    forever begin
      @(negedge clk);
      if (doneA === 1'b1) begin
        if (expQA.size() == 0) begin
          checkOutput("A unexpected done_o", 64'(doneA), 64'(0));
        end else begin
          e = expQA.pop_front();
          checkOutput("A key_o", 64'(keyA), 64'(e.key));
          checkOutput("A err_vec_cnt_o", 64'(errA), 64'(e.err));
          checkOutput("A bit_flip_cnt_o", 64'(flipA), 64'(e.flips));
          checkOutput("A max_hd_o", 64'(maxA), 64'(e.maxhd));
          checkOutput("A busy_o at done", 64'(busyA), 64'(0));
        end
      end
    end
  end

  initial begin : monitorB
    exp_t e;
    forever begin
      @(negedge clk);
      if (doneB === 1'b1) begin
        if (expQB.size() == 0) begin
          checkOutput("B unexpected done_o", 64'(doneB), 64'(0));
        end else begin
          e = expQB.pop_front();
          checkOutput("B key_o", 64'(keyB), 64'(e.key));
          checkOutput("B err_vec_cnt_o", 64'(errB), 64'(e.err));
          checkOutput("B bit_flip_cnt_o", 64'(flipB), 64'(e.flips));
          checkOutput("B max_hd_o", 64'(maxB), 64'(e.maxhd));
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    stepCycle();
    vld    = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] g, input logic [W-1:0] d);
    stepCycle();
    startA = 1'b0;
    startB = 1'b0;
    vld    = 1'b1;
    golden = g;
    locked = g ^ d;
  endtask

  task automatic startTrialA(input logic [KW-1:0] k);
    stepCycle();
    vld    = 1'b0;
    startA = 1'b1;
    keyI   = k;
  endtask

  task automatic sendFourA(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
    applyStimulus(17'h01357, d0);
    applyStimulus(17'h1ACE1, d1);
    applyStimulus(17'h0FFFF, d2);
    applyStimulus(17'h10203, d3);
  endtask

  // Called right after the last accepted vld cycle t; optionally starts a new trial in t+2.
  task automatic checkDoneAfterLast(input string tag, input bit startNext, input logic [KW-1:0] k);
    stepCycle();
    vld = 1'b0;
    @(negedge clk);
    checkOutput({tag, " done_o at t+1"}, 64'(doneA), 64'(0));
    stepCycle();
    if (startNext) begin
      startA = 1'b1;
      keyI   = k;
    end
    @(negedge clk);
    checkOutput({tag, " done_o at t+2"}, 64'(doneA), 64'(1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset busy_o", 64'(busyA), 64'(0));
    checkOutput("reset done_o", 64'(doneA), 64'(0));
    checkOutput("reset key_o", 64'(keyA), 64'(0));
    checkOutput("reset err_vec_cnt_o", 64'(errA), 64'(0));
    checkOutput("reset bit_flip_cnt_o", 64'(flipA), 64'(0));
    checkOutput("reset max_hd_o", 64'(maxA), 64'(0));
    stepCycle();
    rst = 1'b0;

    // Identical outputs: nothing corrupted.
    expQA.push_back(mkExp(32'h01916385, 0, 0, 0));
    startTrialA(32'h01916385);
    applyStimulus(17'h01357, 17'h00000);
    @(negedge clk);
    checkOutput("S1 busy_o after start", 64'(busyA), 64'(1));
    applyStimulus(17'h1ACE1, 17'h00000);
    applyStimulus(17'h0FFFF, 17'h00000);
    applyStimulus(17'h10203, 17'h00000);
    checkDoneAfterLast("S1", 1'b0, '0);
    idleCycle();

    // Every bit flipped in every vector.
    expQA.push_back(mkExp(32'hA5A50002, 4, 68, 17));
    startTrialA(32'hA5A50002);
    sendFourA(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
    checkDoneAfterLast("S2", 1'b0, '0);
    idleCycle();

    // Gapped valid, ignored restart during RUN, ignored fifth sample.
    expQA.push_back(mkExp(32'h00000003, 3, 4, 2));
    startTrialA(32'h00000003);
    applyStimulus(17'h00100, 17'h00001);
    idleCycle();
    applyStimulus(17'h02000, 17'h00003);
    stepCycle();
    vld    = 1'b0;
    startA = 1'b1;
    keyI   = 32'hDEADBEEF;
    applyStimulus(17'h1FFFF, 17'h00000);
    idleCycle();
    applyStimulus(17'h0AAAA, 17'h10000);
    applyStimulus(17'h00000, 17'h1FFFF);
    @(negedge clk);
    checkOutput("S3 done_o at t+1", 64'(doneA), 64'(0));
    stepCycle();
    vld = 1'b0;
    @(negedge clk);
    checkOutput("S3 done_o at t+2", 64'(doneA), 64'(1));
    idleCycle();

    // Reset in the middle of a trial aborts it without done_o.
    startTrialA(32'hBAD00004);
    applyStimulus(17'h01234, 17'h1FFFF);
    applyStimulus(17'h0F0F0, 17'h1FFFF);
    stepCycle();
    vld = 1'b0;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("S4 busy_o after rst", 64'(busyA), 64'(0));
    checkOutput("S4 done_o after rst", 64'(doneA), 64'(0));
    checkOutput("S4 key_o after rst", 64'(keyA), 64'(0));
    checkOutput("S4 err after rst", 64'(errA), 64'(0));
    checkOutput("S4 flips after rst", 64'(flipA), 64'(0));
    checkOutput("S4 max_hd after rst", 64'(maxA), 64'(0));
    repeat (3) idleCycle();
    expQA.push_back(mkExp(32'h00000044, 2, 4, 3));
    startTrialA(32'h00000044);
    sendFourA(17'h00007, 17'h00000, 17'h00000, 17'h00100);
    checkDoneAfterLast("S4 fresh", 1'b0, '0);
    idleCycle();

    // Start in the done_o cycle begins a new trial immediately.
    expQA.push_back(mkExp(32'h66666666, 4, 4, 1));
    expQA.push_back(mkExp(32'h77777777, 2, 19, 17));
    startTrialA(32'h66666666);
    sendFourA(17'h00010, 17'h00010, 17'h00010, 17'h00010);
    checkDoneAfterLast("S6", 1'b1, 32'h77777777);
    stepCycle();
    startA = 1'b0;
    @(negedge clk);
    checkOutput("S6 busy_o after restart", 64'(busyA), 64'(1));
    checkOutput("S6 err cleared", 64'(errA), 64'(0));
    checkOutput("S6 flips cleared", 64'(flipA), 64'(0));
    checkOutput("S6 max_hd cleared", 64'(maxA), 64'(0));
    checkOutput("S6 key_o relatched", 64'(keyA), 64'(32'h77777777));
    sendFourA(17'h00000, 17'h1FFFF, 17'h00003, 17'h00000);
    checkDoneAfterLast("S6 second", 1'b0, '0);
    repeat (3) idleCycle();
    @(negedge clk);
    checkOutput("S6 err held", 64'(errA), 64'(2));
    checkOutput("S6 key held", 64'(keyA), 64'(32'h77777777));

    // Instance B: 2-bit error counter saturates at 3.
    expQB.push_back(mkExp(32'h55555555, 3, 5, 1));
    stepCycle();
    vld    = 1'b0;
    startB = 1'b1;
    keyI   = 32'h55555555;
    applyStimulus(17'h01111, 17'h00001);
    applyStimulus(17'h02222, 17'h00002);
    applyStimulus(17'h03333, 17'h00004);
    applyStimulus(17'h04444, 17'h00008);
    applyStimulus(17'h05555, 17'h10000);
    stepCycle();
    vld = 1'b0;
    stepCycle();
    @(negedge clk);
    checkOutput("S5 done_o at t+2", 64'(doneB), 64'(1));
    repeat (3) idleCycle();

    checkOutput("A all expected results seen", 64'(expQA.size()), 64'(0));
    checkOutput("B all expected results seen", 64'(expQB.size()), 64'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/output_corruption_counter.md
# output_corruption_counter

Downstream scoring stage for locked-netlist simulation. It consumes the locked adder's output stream alongside the golden (unlocked) output for the same operand pair and scores one key trial at a time. Per trial it reports the erroneous-vector count, total flipped output bits (Hamming distance sum) and worst-case per-vector Hamming distance. These figures are the corruption metrics for the Hamming-distance key sweeps.

## Interface
Parameters:
- WIDTH, 17, width of compared result (16-bit adder sum plus carry)
- N_VECTORS, 5000, accepted vectors per trial
- CNT_W, 16, width of erroneous-vector counter
- HD_W, 24, width of flipped-bit accumulator
- KEY_W, 32, key tag width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  begin trial; honoured only when busy_o=0
- key_i  in  KEY_W  key under test, latched on accepted start_i
- vld_i  in  1  locked_i/golden_i valid this cycle
- locked_i  in  WIDTH  locked netlist output
- golden_i  in  WIDTH  reference output
- busy_o  out  1  trial in progress
- done_o  out  1  one-cycle pulse: results final
- key_o  out  KEY_W  latched key tag
- err_vec_cnt_o  out  CNT_W  vectors with any differing bit
- bit_flip_cnt_o  out  HD_W  sum of per-vector Hamming distances
- max_hd_o  out  $clog2(WIDTH+1)  largest per-vector Hamming distance

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start_i=1 clears all counters and max_hd_o, latches key_i into key_o, and moves to RUN with busy_o=1. vld_i is ignored in IDLE.
- RUN: each vld_i=1 is accepted. Stage 1 registers diff=locked_i^golden_i plus a valid bit, and increments the accepted-sample counter.
- Stage 2 (on a valid diff) computes hd=popcount(diff):
  - hd≠0: err_vec_cnt_o+1
  - bit_flip_cnt_o += hd
  - max_hd_o = max(max_hd_o, hd)
- On acceptance of the N_VECTORS-th sample: RUN→DRAIN. Further vld_i is ignored.
- DRAIN: after the stage-2 update of the last sample, done_o pulses for 1 cycle, busy_o drops, and the state returns to IDLE.
- Both counters saturate at all-ones and never wrap.
- Results and key_o are held until the next accepted start_i.
- start_i while busy_o=1 is ignored (no restart, no clear).
- start_i in the done_o cycle is accepted. busy_o is already 0 in that cycle, so a new trial begins.
- vld_i gaps are allowed; only accepted samples count.
- The sample counter is $clog2(N_VECTORS+1) bits.

## Timing
- Reset values: busy_o=0, done_o=0, key_o=0, err_vec_cnt_o=0, bit_flip_cnt_o=0, max_hd_o=0. State is IDLE and pipeline valid bits are cleared.
- rst mid-trial aborts the trial: everything returns to reset values the next cycle, with no done_o.
- busy_o is high the cycle after an accepted start_i.
- Per-sample latency: vld_i in cycle t, so counters reflect that sample in cycle t+2.
- done_o is high in cycle t+2, where t is the cycle of the last accepted vld_i. Outputs are final in that same cycle.
- Throughput: one sample per cycle, back-to-back vld_i supported.

## Structure
- Shared package corruption_pkg holds:
  - the state enum (IDLE, RUN, DRAIN)
  - default WIDTH=17 and KEY_W=32 constants
  - saturating-add helper function
- One sub-module, popcount: combinational, parameterised WIDTH, output $clog2(WIDTH+1) bits. Instantiated in stage 2.

## Test plan
Bench uses N_VECTORS=4.
1. golden_i==locked_i for 4 back-to-back vectors, key_i=32'h01916385 → err 0, flips 0, max_hd 0, key_o=32'h01916385, done_o 2 cycles after 4th vld_i.
2. locked_i=golden_i^17'h1FFFF for 4 vectors → err 4, flips 68, max_hd 17.
3. Diffs 17'h00001, 17'h00003, 0, 17'h10000 with 1-cycle vld_i gaps → err 3, flips 4, max_hd 2. 5th vld_i and start_i pulsed during RUN are ignored.
4. rst after 2 accepted vectors of scenario 2 → all outputs 0 next cycle, busy_o=0, no done_o. A subsequent fresh trial scores cleanly.
5. CNT_W=2, N_VECTORS=5, all 5 vectors differ by 1 bit → err_vec_cnt_o saturates at 3, flips 5.
6. start_i asserted in the done_o cycle → new trial accepted, counters cleared next cycle, busy_o=1.
